// File: rtl/spi_slave_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrl_pkg
// Shared definitions for the SPI slave front-end and the single-port RAM:
// RAM command encodings, SPI controller state encoding and frame geometry.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_slave_ctrl_pkg;

  localparam int FRAME_W = 10;  // {cmd[1:0], payload[7:0]}
  localparam int DATA_W  = 8;   // read data returned on MISO

  // Bit counter must be able to hold the value FRAME_W itself.
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int SH_W  = $clog2(DATA_W);

  // RAM command encodings (frame bits [9:8]). The CMD_ prefix keeps
  // CMD_READ_DATA distinct from the READ_DATA controller state below.
  typedef enum logic [1:0] {
    CMD_WRITE_ADDRESS = 2'b00,
    CMD_WRITE_DATA    = 2'b01,
    CMD_READ_ADDRESS  = 2'b10,
    CMD_READ_DATA     = 2'b11
  } ram_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrl_if
// Bundles the SPI pins and the RAM-side rx/tx handshake of the SPI slave.
//   SS_n, MOSI        : SPI select (active low) and serial data in
//   MISO              : serial read data out, MSB first
//   rx_data, rx_valid : assembled command frame and its one-cycle strobe
//   tx_data, tx_valid : RAM read data and its valid flag
// Modports: slave (the controller), master (SPI master + RAM side).
// ---------------------------------------------------------------------------
interface spi_slave_ctrl_if;
  import spi_slave_ctrl_pkg::*;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_piso_tx.sv
// ---------------------------------------------------------------------------
// spi_piso_tx
// 8-bit load/shift serialiser driving MISO.
//   clk, rst : clock, synchronous active-high reset
//   abort    : drop any in-flight byte and force sout low
//   load     : capture data; its MSB appears on sout the following cycle
//   data     : byte to serialise
//   sout     : registered serial output, 0 when not shifting
//   last     : high during the cycle the final bit is on sout
// ---------------------------------------------------------------------------
module spi_piso_tx
  import spi_slave_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              sout,
  output logic              last
);

  logic [DATA_W-1:0] sr;
  logic [SH_W-1:0]   left;   // bits still to present after the current one
  logic              busy;

  assign last = busy && (left == '0);

  // NOTE: registered state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      sr   <= '0;
      left <= '0;
      busy <= 1'b0;
      sout <= 1'b0;
    end else if (load) begin
      sout <= data[DATA_W-1];
      sr   <= {data[DATA_W-2:0], 1'b0};
      left <= SH_W'(DATA_W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (left != '0) begin
        sout <= sr[DATA_W-1];
        sr   <= {sr[DATA_W-2:0], 1'b0};
        left <= left - SH_W'(1);
      end else begin
        sout <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrl
// SPI slave front-end for the single-port RAM. Deserialises 10-bit command
// frames from MOSI, strobes them to the RAM, and for read-data frames
// serialises the RAM's reply byte back out on MISO.
//   clk : system clock, also the SPI bit clock
//   rst : synchronous active-high reset
//   bus : spi_slave_ctrl_if.slave (SS_n, MOSI, MISO, rx_*, tx_*)
// ---------------------------------------------------------------------------
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  spi_slave_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_W - 1);

  spi_state_e         state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] shreg;        // frame bits received so far
  logic               rd_addr_seen; // a read address precedes the next read
  logic               await_tx;     // read-data frame done, RAM reply pending
  logic [FRAME_W-1:0] rx_data_q;
  logic               rx_valid_q;
  logic               tx_load;
  logic               tx_last;
  logic               miso;

  // The reply is accepted only inside the wait window, so stray tx_valid
  // pulses (mid-frame, or after the byte went out) are ignored.
  assign tx_load = (state == READ_DATA) && await_tx && bus.tx_valid && !bus.SS_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      rd_addr_seen <= 1'b0;
      await_tx     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;  // strobe: high only on the completing edge
      if (bus.SS_n) begin
        // Deselect ends the frame; an incomplete frame leaves no trace.
        state    <= IDLE;
        bit_cnt  <= '0;
        await_tx <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            shreg   <= {{(FRAME_W-2){1'b0}}, bus.MOSI};
            bit_cnt <= CNT_W'(1);
            // Only frame bit 9 steers the FSM; bit 8 goes to the RAM as-is.
            if (!bus.MOSI)        state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Bits beyond the tenth are ignored until deselect.
            if (bit_cnt < FRAME_CNT) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              shreg   <= {shreg[FRAME_W-3:0], bus.MOSI};
              if (bit_cnt == LAST_CNT) begin
                rx_data_q  <= {shreg, bus.MOSI};
                rx_valid_q <= 1'b1;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) await_tx     <= 1'b1;
              end
            end
            if (tx_load) await_tx     <= 1'b0;
            if (tx_last) rd_addr_seen <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_piso_tx u_piso_tx (
    .clk   (clk),
    .rst   (rst),
    .abort (bus.SS_n),
    .load  (tx_load),
    .data  (bus.tx_data),
    .sout  (miso),
    .last  (tx_last)
  );

  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_ctrl
// Transaction-level driver with a protocol model; expected frames and MISO
// bits are queued as stimulus is issued, and a monitor compares them
// against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_spi_slave_ctrl;
  import spi_slave_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  spi_slave_ctrl_if bus ();

  spi_slave_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         k;      // edge after which rx_valid must be high
    logic [9:0] frame;
  } exp_frame_t;

  exp_frame_t fq[$];          // expected rx frames
  int         rst_q[$];       // edges at which rst is applied
  bit         exp_miso [int]; // expected MISO after edge k (absent = 0)
  logic [9:0] hold_rx = '0;   // rx_data value the RAM should be seeing
  bit         rd_seen = 1'b0; // model: read address received
  bit         mon_en  = 1'b0;

  logic [9:0] rf;
  int         ra;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    exp_frame_t e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (rst_q.size() > 0 && rst_q[0] == cyc) begin
        rst_q.delete(0);
        hold_rx = '0;
      end
      if (bus.rx_valid) begin
        if (fq.size() == 0) begin
          check("rx_valid_spurious", 32'(bus.rx_valid), 32'(0));
        end else begin
          e = fq.pop_front();
          check("rx_valid_time", 32'(cyc), 32'(e.k));
          check("rx_data", 32'(bus.rx_data), 32'(e.frame));
          hold_rx = e.frame;
        end
      end else if (fq.size() > 0 && fq[0].k <= cyc) begin
        e = fq.pop_front();
        check("rx_valid_missing", 32'(bus.rx_valid), 32'(1));
        hold_rx = e.frame;
      end
      check("rx_data_hold", 32'(bus.rx_data), 32'(hold_rx));
      check("miso", 32'(bus.MISO), 32'(exp_miso.exists(cyc) ? exp_miso[cyc] : 1'b0));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic ss, input logic mosi, input logic txv);
    bus.SS_n     = ss;
    bus.MOSI     = mosi;
    bus.tx_valid = txv;
    bus.tx_data  = 8'($urandom);
  endtask

  // One SS_n-low transaction. abort_at = frame bits sampled before SS_n
  // rises (10 = full frame); delay = idle cycles before the RAM reply;
  // rst_bit = MISO bit number (1-based) during which reset hits, 0 = none.
  task automatic frame_txn(input logic [9:0] f, input int abort_at, input int delay,
                           input logic [7:0] txd, input int rst_bit);
    bit rd_data;
    int t;
    drive(1'b0, 1'($urandom), 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at) break;
      drive(1'b0, f[9-i], i == 4);  // tx_valid mid-frame must be ignored
      if (i == 9) fq.push_back('{k: cyc + 1, frame: f});
      step();
    end
    if (abort_at < 10) begin
      drive(1'b1, 1'b0, 1'b0);
      step();
      return;
    end
    rd_data = f[9] && rd_seen;
    if (f[9] && !rd_seen) rd_seen = 1'b1;
    if (rd_data) begin
      for (int d = 0; d < delay; d++) begin
        drive(1'b0, 1'($urandom), 1'b0);
        step();
      end
      drive(1'b0, 1'($urandom), 1'b1);
      bus.tx_data = txd;
      t = cyc + 1;
      for (int j = 0; j < 8; j++)
        if (rst_bit == 0 || j < rst_bit) exp_miso[t + j] = txd[7-j];
      step();
      for (int j = 1; j <= 8; j++) begin
        if (rst_bit != 0 && j == rst_bit) begin
          rst = 1'b1;
          drive(1'b1, 1'b0, 1'b0);
          rst_q.push_back(cyc + 1);
          rd_seen = 1'b0;
          step();
          rst = 1'b0;
          return;
        end
        drive(1'b0, 1'($urandom), 1'b0);
        step();
      end
      rd_seen = 1'b0;
    end
    drive(1'b0, 1'($urandom), 1'b1);  // outside the wait window: ignored
    step();
    drive(1'b1, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    frame_txn(10'h0A5, 10, 0, 8'h00, 0);  // write address
    frame_txn(10'h13C, 10, 0, 8'h00, 0);  // write data
    frame_txn(10'h207, 10, 0, 8'h00, 0);  // read address
    frame_txn(10'h300, 10, 0, 8'hC3, 0);  // read data, immediate reply
    frame_txn(10'h1FF, 6, 0, 8'h00, 0);   // abort after 6 bits
    frame_txn(10'h2AA, 10, 0, 8'h00, 0);
    frame_txn(10'h35A, 10, 5, 8'h5A, 0);  // reply 5 cycles late
    frame_txn(10'h215, 10, 0, 8'h00, 0);
    frame_txn(10'h3F0, 10, 2, 8'hA6, 4);  // reset during 4th MISO bit
    frame_txn(10'h255, 10, 0, 8'h00, 0);  // read address again after reset
    frame_txn(10'h301, 10, 1, 8'h81, 0);
    frame_txn(10'h2CC, 9, 0, 8'h00, 0);   // SS_n rises on the bit-0 edge
    frame_txn(10'h3CC, 10, 0, 8'h00, 0);  // still treated as read address
    frame_txn(10'h3E7, 10, 3, 8'h7E, 0);

    for (int n = 0; n < 40; n++) begin
      rf = 10'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
      frame_txn(rf, ra, int'($urandom_range(0, 6)), 8'($urandom), 0);
    end

    repeat (4) step();
    check("frames_drained", 32'(fq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
